// File: rtl/stream_demux_1to2_pkg.sv
// Shared defaults and constants for the 1-to-2 stream demultiplexer and its
// per-channel buffer.
package stream_demux_1to2_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 2;
  localparam int CNT_W      = 8;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/demux_chan_fifo.sv
// One output channel: a DEPTH-entry FIFO with a registered head word and a
// wrapping delivered-byte counter.
module demux_chan_fifo
  import stream_demux_1to2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              full_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output cnt_t              count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [DATA_W-1:0] data_q, data_d;
  cnt_t              count_q, count_d;
  logic              push;
  logic              pop;

  assign full_o  = (occ_q == OCC_FULL);
  assign valid_o = (occ_q != '0);
  assign push    = push_i & ~full_o;
  assign pop     = valid_o & ready_i;
  assign data_o  = data_q;
  assign count_o = count_q;

  // NOTE: every signal driven here gets its default first, so no path leaves a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    data_d   = data_q;
    count_d  = count_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    // The head register tracks the entry rd_ptr_d will point at; when that
    // slot is being written this very cycle, the incoming word bypasses memory.
    if (occ_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) data_d = push_data_i;
      else                                data_d = mem_q[rd_ptr_d];
    end
  end

  // NOTE: the storage array is deliberately not reset; only data_q is visible,
  // and it is cleared by reset, so stale entries can never reach the output.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      data_q   <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      data_q   <= data_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/stream_demux_1to2.sv
// 1-to-2 stream demultiplexer: steers each accepted input byte to the channel
// named by s_sel; each channel buffers independently.
module stream_demux_1to2
  import stream_demux_1to2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sel,
  output logic              m0_valid,
  input  logic              m0_ready,
  output logic [DATA_W-1:0] m0_data,
  output logic [CNT_W-1:0]  m0_count,
  output logic              m1_valid,
  input  logic              m1_ready,
  output logic [DATA_W-1:0] m1_data,
  output logic [CNT_W-1:0]  m1_count
);

  logic full0, full1;
  logic accept;
  logic push0, push1;

  // Ready looks only at the addressed channel, so a full channel never blocks
  // the other one; reset forces it low whichever channel is selected.
  assign s_ready = ~rst & ((s_sel == CH1) ? ~full1 : ~full0);
  assign accept  = s_valid & s_ready;
  assign push0   = accept & (s_sel == CH0);
  assign push1   = accept & (s_sel == CH1);

  demux_chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_chan0 (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push0),
    .push_data_i(s_data),
    .full_o     (full0),
    .valid_o    (m0_valid),
    .ready_i    (m0_ready),
    .data_o     (m0_data),
    .count_o    (m0_count)
  );

  demux_chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_chan1 (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push1),
    .push_data_i(s_data),
    .full_o     (full1),
    .valid_o    (m1_valid),
    .ready_i    (m1_ready),
    .data_o     (m1_data),
    .count_o    (m1_count)
  );

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed, table-driven bench for stream_demux_1to2 with default parameters.
module tb_stream_demux_1to2;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_ready, s_sel;
  logic [7:0] s_data;
  logic       m0_valid, m0_ready, m1_valid, m1_ready;
  logic [7:0] m0_data, m1_data, m0_count, m1_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stream_demux_1to2 dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sel(s_sel),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_data(m0_data), .m0_count(m0_count),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_data(m1_data), .m1_count(m1_count)
  );

  typedef struct {
    logic       sv;
    logic       sel;
    logic [7:0] d;
    logic       r0;
    logic       r1;
    logic       e_rdy;
    logic       e_v0;
    logic [7:0] e_d0;
    logic       e_v1;
    logic [7:0] e_d1;
    logic [7:0] e_c0;
    logic [7:0] e_c1;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic sel, input logic [7:0] d,
                       input logic r0, input logic r1);
    s_valid  = sv;
    s_sel    = sel;
    s_data   = d;
    m0_ready = r0;
    m1_ready = r1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // sv sel data r0 r1 | rdy v0 d0 v1 d1 c0 c1 (outputs before the edge)
    vecs[0]  = '{1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0, 8'd0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 8'h00, 8'd0, 8'd0};
    vecs[2]  = '{1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 8'h00, 8'd1, 8'd0};
    vecs[3]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA1, 1'b1, 8'h10, 8'd1, 8'd0};
    vecs[4]  = '{1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA1, 1'b1, 8'h10, 8'd1, 8'd0};
    vecs[5]  = '{1'b1, 1'b0, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA1, 1'b1, 8'h10, 8'd1, 8'd0};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB0, 1'b1, 8'h10, 8'd1, 8'd0};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB0, 1'b1, 8'h11, 8'd1, 8'd1};
    vecs[8]  = '{1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB0, 1'b0, 8'h11, 8'd1, 8'd2};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 8'h11, 8'd2, 8'd2};
    vecs[10] = '{1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 8'h11, 8'd2, 8'd2};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 8'h11, 8'd2, 8'd2};
    vecs[12] = '{1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 8'h11, 8'd2, 8'd2};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h66, 1'b0, 8'h11, 8'd3, 8'd2};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h66, 1'b0, 8'h11, 8'd4, 8'd2};

    // Reset state, with both select values.
    drive(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    check("rst s_ready sel0", 32'(s_ready), 32'd0);
    s_sel = 1'b1;
    #1;
    check("rst s_ready sel1", 32'(s_ready), 32'd0);
    check("rst m0_valid", 32'(m0_valid), 32'd0);
    check("rst m1_valid", 32'(m1_valid), 32'd0);
    check("rst m0_data", 32'(m0_data), 32'd0);
    check("rst m1_data", 32'(m1_data), 32'd0);
    check("rst m0_count", 32'(m0_count), 32'd0);
    check("rst m1_count", 32'(m1_count), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic delivery, channel-1 backpressure, push+pop on one channel, full+pop.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].sv, vecs[i].sel, vecs[i].d, vecs[i].r0, vecs[i].r1);
      #1;
      check($sformatf("v%0d s_ready", i), 32'(s_ready), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d m0_valid", i), 32'(m0_valid), 32'(vecs[i].e_v0));
      check($sformatf("v%0d m1_valid", i), 32'(m1_valid), 32'(vecs[i].e_v1));
      if (vecs[i].e_v0) check($sformatf("v%0d m0_data", i), 32'(m0_data), 32'(vecs[i].e_d0));
      if (vecs[i].e_v1) check($sformatf("v%0d m1_data", i), 32'(m1_data), 32'(vecs[i].e_d1));
      check($sformatf("v%0d m0_count", i), 32'(m0_count), 32'(vecs[i].e_c0));
      check($sformatf("v%0d m1_count", i), 32'(m1_count), 32'(vecs[i].e_c1));
      tick();
    end

    // Fill both channels, then assert reset between clock edges.
    drive(1'b1, 1'b0, 8'hC0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 8'hD0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 8'hD1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("full s_ready sel0", 32'(s_ready), 32'd0);
    check("full m0_data", 32'(m0_data), 32'hC0);
    s_sel = 1'b1;
    #1;
    check("full s_ready sel1", 32'(s_ready), 32'd0);
    check("full m1_data", 32'(m1_data), 32'hD0);
    rst = 1'b1;
    #1;
    check("async m0_valid", 32'(m0_valid), 32'd0);
    check("async m1_valid", 32'(m1_valid), 32'd0);
    check("async m0_count", 32'(m0_count), 32'd0);
    check("async m1_count", 32'(m1_count), 32'd0);
    check("async m0_data", 32'(m0_data), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post-rst s_ready sel1", 32'(s_ready), 32'd1);
    s_sel = 1'b0;
    #1;
    check("post-rst s_ready sel0", 32'(s_ready), 32'd1);
    check("post-rst m0_valid", 32'(m0_valid), 32'd0);
    drive(1'b1, 1'b0, 8'hE5, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("first hs m0_valid", 32'(m0_valid), 32'd1);
    check("first hs m0_data", 32'(m0_data), 32'hE5);
    check("first hs m1_valid", 32'(m1_valid), 32'd0);

    // Alternating select with both consumers always ready.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'(i & 1), 8'(i), 1'b1, 1'b1);
      #1;
      check($sformatf("alt%0d s_ready", i), 32'(s_ready), 32'd1);
      if (i > 0) begin
        if (((i - 1) & 1) == 0) begin
          check($sformatf("alt%0d m0_valid", i), 32'(m0_valid), 32'd1);
          check($sformatf("alt%0d m0_data", i), 32'(m0_data), 32'(i - 1));
          check($sformatf("alt%0d m1_valid", i), 32'(m1_valid), 32'd0);
        end else begin
          check($sformatf("alt%0d m1_valid", i), 32'(m1_valid), 32'd1);
          check($sformatf("alt%0d m1_data", i), 32'(m1_data), 32'(i - 1));
          check($sformatf("alt%0d m0_valid", i), 32'(m0_valid), 32'd0);
        end
      end
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    #1;
    check("alt last m1_valid", 32'(m1_valid), 32'd1);
    check("alt last m1_data", 32'(m1_data), 32'h07);
    check("alt last m0_valid", 32'(m0_valid), 32'd0);
    tick();
    check("alt m0_count", 32'(m0_count), 32'd4);
    check("alt m1_count", 32'(m1_count), 32'd4);

    // 256 deliveries on channel 1: the counter wraps to zero.
    do_reset();
    begin
      int stalls;
      stalls = 0;
      for (int i = 0; i < 256; i++) begin
        drive(1'b1, 1'b1, 8'(i), 1'b0, 1'b1);
        #1;
        if (s_ready !== 1'b1) stalls++;
        tick();
      end
      check("wrap stalls", 32'(stalls), 32'd0);
    end
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    #1;
    check("wrap m1_count 255", 32'(m1_count), 32'd255);
    check("wrap last m1_data", 32'(m1_data), 32'hFF);
    tick();
    check("wrap m1_count 0", 32'(m1_count), 32'd0);
    check("wrap m1_valid", 32'(m1_valid), 32'd0);
    check("wrap m0_count", 32'(m0_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_demux_1to2.md
STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the payload width of the input and both output channels.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the per-channel buffer entries; legal values are powers of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port s_valid, input, 1 bit: input byte present.
REQ-006 The block SHALL have port s_ready, output, 1 bit: block accepts the input byte this cycle.
REQ-007 The block SHALL have port s_data, input, DATA_W bits: input payload.
REQ-008 The block SHALL have port s_sel, input, 1 bit: destination channel, 0 = channel 0, 1 = channel 1.
REQ-009 The block SHALL have ports m0_valid/m1_valid, output, 1 bit each: channel has a byte.
REQ-010 The block SHALL have ports m0_ready/m1_ready, input, 1 bit each: consumer takes the byte.
REQ-011 The block SHALL have ports m0_data/m1_data, output, DATA_W bits each: channel head payload.
REQ-012 The block SHALL have ports m0_count/m1_count, output, 8 bits each: delivered-byte counter per channel.

Function
REQ-013 Input handshake SHALL occur on a cycle with s_valid=1 and s_ready=1; s_sel and s_data are sampled on that edge.
REQ-014 s_ready SHALL be combinational: high exactly when the buffer of channel s_sel is not full; independent of s_valid and of the other channel.
REQ-015 An accepted byte SHALL be written only to the buffer of channel s_sel; the other channel is untouched.
REQ-016 Latency SHALL be 1 cycle: a byte accepted into an empty channel raises mN_valid on the next cycle; no combinational input-to-output path.
REQ-017 Each channel SHALL deliver bytes in acceptance order (FIFO); output handshake occurs on mN_valid=1 and mN_ready=1.
REQ-018 mN_valid SHALL be high exactly when channel N holds at least one byte; mN_data SHALL equal the head entry and stay stable while mN_valid=1 and mN_ready=0.
REQ-019 mN_data SHALL hold its last value when the channel is empty; its value is don't-care then.
REQ-020 Simultaneous push and pop on one channel SHALL leave its occupancy unchanged; with the channel full, s_ready is 0 so no push occurs even if a pop happens that cycle (no full pass-through).
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; occupancy ranges 0..DEPTH, full at DEPTH, empty at 0.
REQ-022 One channel being full SHALL NOT stall traffic addressed to the other channel.
REQ-023 mN_count SHALL increment by 1 on each channel-N output handshake and wrap 255 -> 0.
REQ-024 Bytes offered with s_valid=1 and s_ready=0 SHALL be neither stored nor counted; the source must hold them.

Reset
REQ-025 While rst=1, s_ready, m0_valid and m1_valid SHALL be 0, regardless of s_sel.
REQ-026 While rst=1, m0_data, m1_data, m0_count and m1_count SHALL be 0; both buffers empty with pointers at 0.
REQ-027 Assertion of rst mid-transfer SHALL discard all buffered bytes immediately, asynchronously to clk.
REQ-028 The first handshake SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-029 A shared package SHALL hold the DATA_W and DEPTH defaults, the counter width (8), and the channel-index constants CH0=0 and CH1=1.
REQ-030 One sub-module demux_chan_fifo SHALL implement a single channel's buffer, occupancy and counter.
REQ-031 It SHALL be instantiated twice; the top level holds only steering and s_ready selection.

Verification
REQ-032 Scenario: after reset, send 0xA1 with sel=0 -> next cycle m0_valid=1, m0_data=0xA1, m1_valid=0; pop with m0_ready=1 -> m0_count=1.
REQ-033 Scenario: m1_ready=0; send 0x10, 0x11 with sel=1 -> s_ready=0 for sel=1 on the third attempt; sel=0 traffic is still accepted; then drain m1 -> 0x10 then 0x11.
REQ-034 Scenario: channel 0 holds 1 byte; push 0x55 and pop on the same cycle -> occupancy stays 1, next head is 0x55.
REQ-035 Scenario: alternate sel 0/1 for bytes 0x00..0x07 with both consumers always ready -> m0 sees 0x00,0x02,0x04,0x06 and m1 sees 0x01,0x03,0x05,0x07, no stalls.
REQ-036 Scenario: deliver 256 bytes on channel 1 -> m1_count returns to 0x00 (wrap).
REQ-037 Scenario: assert rst asynchronously with both channels full -> all valids 0, counts 0 at once; after release, s_ready=1 for both sel values.
